// File: rtl/ad_bus_arb_if.sv
// ad_bus_arb_if: requester/bus signal bundle for the two-requester ad bus arbiter.
interface ad_bus_arb_if #(parameter int WIDTH = 16);
  logic [1:0] req;
  logic [WIDTH-1:0] wdata0;
  logic [WIDTH-1:0] wdata1;
  logic [1:0] gnt;
  logic [WIDTH-1:0] regff;
  logic [2*WIDTH-1:0] read;
  logic done;
  logic busy;
  modport master (output req, wdata0, wdata1, input gnt, regff, read, done, busy);
  modport slave (input req, wdata0, wdata1, output gnt, regff, read, done, busy);
endinterface

// File: rtl/ad_bus_arb.sv
// ad_bus_arb: round-robin arbiter driving one latched word onto a shared ad bus for HOLD cycles,
// followed by a one-cycle turnaround so two words never drive the bus back to back.
module ad_bus_arb #(
  parameter int WIDTH = 16,
  parameter int HOLD = 2
) (
  input logic clk,
  input logic reset,
  ad_bus_arb_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic last_q, last_d;
  logic read_q, read_d;
  logic done_q, done_d;
  logic [1:0] gnt_q, gnt_d;
  logic [WIDTH-1:0] regff_q, regff_d;
  logic pick;
  // a tie goes to whoever was not served last
  assign pick = &bus.req ? ~last_q : bus.req[1];
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    last_d = last_q;
    gnt_d = gnt_q;
    regff_d = regff_q;
    read_d = 1'b1;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (|bus.req) begin
        state_d = DRIVE;
        cnt_d = 4'(HOLD - 1);
        gnt_d = pick ? 2'b10 : 2'b01;
        regff_d = pick ? bus.wdata1 : bus.wdata0;
        read_d = 1'b0;
      end
      DRIVE: if (cnt_q == 4'd0) begin
        state_d = TURN;
        gnt_d = 2'b00;
        done_d = 1'b1;
        last_d = gnt_q[1];
      end else begin
        cnt_d = cnt_q - 4'd1;
        read_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        gnt_d = 2'b00;
      end
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      last_q <= 1'b1;
      gnt_q <= '0;
      regff_q <= '0;
      read_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      gnt_q <= gnt_d;
      regff_q <= regff_d;
      read_q <= read_d;
      done_q <= done_d;
    end
  assign bus.gnt = gnt_q;
  assign bus.regff = regff_q;
  assign bus.read = {(2*WIDTH){read_q}};
  assign bus.done = done_q;
  assign bus.busy = state_q != IDLE;
endmodule

// File: tb/tb_ad_bus_arb.sv
// tb_ad_bus_arb: three arbiters (HOLD 2, 4, 1) share stimulus and are checked against a
// transaction-age reference model.
module tb_ad_bus_arb;
  localparam int HL [3] = '{2, 4, 1};
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] req = 2'b00;
  logic [15:0] wdata0 = '0;
  logic [15:0] wdata1 = '0;
  logic [2:0][1:0] gnt_a;
  logic [2:0][15:0] regff_a;
  logic [2:0][31:0] read_a;
  logic [2:0] done_a, busy_a;
  int n_chk = 0;
  int n_fail = 0;
  int age [3] = '{100, 100, 100};
  logic win [3];
  logic lst [3];
  logic [15:0] m_regff [3];
  logic w;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : d
    ad_bus_arb_if #(.WIDTH(16)) bus ();
    ad_bus_arb #(.WIDTH(16), .HOLD(HL[g])) u (.clk(clk), .reset(reset), .bus(bus));
    assign bus.req = req;
    assign bus.wdata0 = wdata0;
    assign bus.wdata1 = wdata1;
    assign gnt_a[g] = bus.gnt;
    assign regff_a[g] = bus.regff;
    assign read_a[g] = bus.read;
    assign done_a[g] = bus.done;
    assign busy_a[g] = bus.busy;
  end

  // age = edges since the grant: 1..HOLD driving, HOLD+1 turnaround, HOLD+2 and up idle
  always @(posedge clk)
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        age[k] = 100;
        lst[k] = 1'b1;
        m_regff[k] = '0;
      end else if (age[k] >= HL[k] + 2 && req != 2'b00) begin
        w = (req == 2'b11) ? ~lst[k] : req[1];
        lst[k] = w;
        win[k] = w;
        m_regff[k] = w ? wdata1 : wdata0;
        age[k] = 1;
      end else if (age[k] < 100) age[k]++;
    end

  function automatic logic [1:0] e_gnt(int k);
    return age[k] <= HL[k] ? (win[k] ? 2'b10 : 2'b01) : 2'b00;
  endfunction
  function automatic logic [31:0] e_read(int k);
    return {32{age[k] > HL[k]}};
  endfunction
  function automatic logic e_done(int k);
    return age[k] == HL[k] + 1;
  endfunction
  function automatic logic e_busy(int k);
    return age[k] <= HL[k] + 1;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    req = 2'b11;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if ({gnt_a[k], regff_a[k], read_a[k], done_a[k], busy_a[k]} !== {2'b00, 16'h0, 32'hFFFF_FFFF, 1'b0, 1'b0}) begin
          n_fail++;
          $display("FAIL reset h%0d t=%0t got gnt=%b regff=%h read=%h done=%b busy=%b", HL[k], $time, gnt_a[k], regff_a[k], read_a[k], done_a[k], busy_a[k]);
        end
      end
    end
    reset = 1'b0;
    req = 2'b00;
  endtask

  task automatic test_single();
    for (int c = 0; c < 9; c++) begin
      req = (c == 0) ? 2'b01 : 2'b00;
      wdata0 = (c == 0) ? 16'hA5A5 : 16'h5A5A;
      wdata1 = 16'hDEAD;
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if ({gnt_a[k], regff_a[k], read_a[k], done_a[k], busy_a[k]} !== {e_gnt(k), m_regff[k], e_read(k), e_done(k), e_busy(k)}) begin
          n_fail++;
          $display("FAIL single h%0d t=%0t got gnt=%b regff=%h read=%h done=%b busy=%b exp gnt=%b regff=%h read=%h done=%b busy=%b", HL[k], $time, gnt_a[k], regff_a[k], read_a[k], done_a[k], busy_a[k], e_gnt(k), m_regff[k], e_read(k), e_done(k), e_busy(k));
        end
      end
    end
  endtask

  task automatic test_tie();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    wdata0 = 16'h1111;
    wdata1 = 16'h2222;
    for (int c = 0; c < 24; c++) begin
      req = (c < 16) ? 2'b11 : 2'b00;
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if ({gnt_a[k], regff_a[k], read_a[k], done_a[k], busy_a[k]} !== {e_gnt(k), m_regff[k], e_read(k), e_done(k), e_busy(k)}) begin
          n_fail++;
          $display("FAIL tie h%0d t=%0t got gnt=%b regff=%h read=%h done=%b busy=%b exp gnt=%b regff=%h read=%h done=%b busy=%b", HL[k], $time, gnt_a[k], regff_a[k], read_a[k], done_a[k], busy_a[k], e_gnt(k), m_regff[k], e_read(k), e_done(k), e_busy(k));
        end
      end
    end
  endtask

  task automatic test_drop();
    for (int c = 0; c < 12; c++) begin
      req = (c == 0) ? 2'b10 : 2'b00;
      wdata1 = (c == 0) ? 16'hBEEF : 16'h0F0F;
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if ({gnt_a[k], regff_a[k], read_a[k], done_a[k], busy_a[k]} !== {e_gnt(k), m_regff[k], e_read(k), e_done(k), e_busy(k)}) begin
          n_fail++;
          $display("FAIL drop h%0d t=%0t got gnt=%b regff=%h read=%h done=%b busy=%b exp gnt=%b regff=%h read=%h done=%b busy=%b", HL[k], $time, gnt_a[k], regff_a[k], read_a[k], done_a[k], busy_a[k], e_gnt(k), m_regff[k], e_read(k), e_done(k), e_busy(k));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    wdata0 = 16'hC3C3;
    for (int c = 0; c < 10; c++) begin
      req = (c == 0) ? 2'b01 : 2'b00;
      reset = (c == 2);
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if ({gnt_a[k], regff_a[k], read_a[k], done_a[k], busy_a[k]} !== {e_gnt(k), m_regff[k], e_read(k), e_done(k), e_busy(k)}) begin
          n_fail++;
          $display("FAIL reset_mid h%0d t=%0t got gnt=%b regff=%h read=%h done=%b busy=%b exp gnt=%b regff=%h read=%h done=%b busy=%b", HL[k], $time, gnt_a[k], regff_a[k], read_a[k], done_a[k], busy_a[k], e_gnt(k), m_regff[k], e_read(k), e_done(k), e_busy(k));
        end
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] pd = '0;
    for (int c = 0; c < 400; c++) begin
      req = 2'($urandom);
      wdata0 = 16'($urandom);
      wdata1 = 16'($urandom);
      reset = ($urandom_range(0, 99) < 3);
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if ({gnt_a[k], regff_a[k], read_a[k], done_a[k], busy_a[k]} !== {e_gnt(k), m_regff[k], e_read(k), e_done(k), e_busy(k)}) begin
          n_fail++;
          $display("FAIL random h%0d t=%0t got gnt=%b regff=%h read=%h done=%b busy=%b exp gnt=%b regff=%h read=%h done=%b busy=%b", HL[k], $time, gnt_a[k], regff_a[k], read_a[k], done_a[k], busy_a[k], e_gnt(k), m_regff[k], e_read(k), e_done(k), e_busy(k));
        end
        n_chk++;
        if (!$onehot0(gnt_a[k]) || (done_a[k] && pd[k]) || ((gnt_a[k] == 2'b00) != (read_a[k] != 32'h0))) begin
          n_fail++;
          $display("FAIL invariant h%0d t=%0t got gnt=%b done=%b prev_done=%b read=%h", HL[k], $time, gnt_a[k], done_a[k], pd[k], read_a[k]);
        end
        pd[k] = done_a[k];
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_drop();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ad_bus_arb.md
AD_BUS_ARB -- requirements
Module: ad_bus_arb

Interface
REQ-001 Parameter WIDTH, default 16: width of each requester data word and of the regff register.
REQ-002 Parameter HOLD, default 2: number of cycles a granted word is driven onto the bus; legal range 1..15.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 req  input  2  request level per requester: bit 0 is requester 0, bit 1 is requester 1.
REQ-006 wdata0  input  WIDTH  requester 0 data, sampled only in the grant cycle.
REQ-007 wdata1  input  WIDTH  requester 1 data, sampled only in the grant cycle.
REQ-008 gnt  output  2  one-hot grant, or all zero; registered.
REQ-009 regff  output  WIDTH  latched data word of the current or most recent transaction; registered.
REQ-010 read  output  2*WIDTH  bufif0 enable vector for the shared ad bus (0 = drive); registered; all bits always equal.
REQ-011 done  output  1  one-cycle completion pulse; registered.
REQ-012 busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 The block SHALL implement three states: IDLE, DRIVE and TURN.
REQ-014 In IDLE with req==0, the block SHALL stay in IDLE with gnt=0, read all-ones and done=0.
REQ-015 In IDLE with exactly one req bit set, the block SHALL enter DRIVE at the next edge, set gnt to that requester and load regff from that requester's wdata.
REQ-016 In IDLE with req==2'b11, the block SHALL grant the requester not served last, using round-robin on a 1-bit last-served pointer.
REQ-017 Grant latency SHALL be one cycle: req is sampled at edge N, and gnt, regff and read=0 are all visible after edge N.
REQ-018 On DRIVE entry, a down-counter SHALL load HOLD-1; DRIVE SHALL last exactly HOLD cycles, with gnt held and read all-zeros.
REQ-019 When the counter is 0 in DRIVE, the next state SHALL be TURN.
REQ-020 TURN SHALL last exactly one cycle, with gnt=0, read all-ones and done=1; the last-served pointer SHALL update to the granted requester at TURN entry.
REQ-021 TURN SHALL always go to IDLE, so the minimum spacing between grant starts is HOLD+2 cycles and the bus is never driven by two words in adjacent cycles.
REQ-022 req and wdata SHALL be ignored outside IDLE; a req drop during DRIVE SHALL NOT shorten the transaction.
REQ-023 A requester holding req high SHALL be re-served; when both requests stay high, the grants SHALL alternate 0,1,0,1.
REQ-024 regff SHALL retain its value through TURN and IDLE and change only on a grant.
REQ-025 busy SHALL be high in DRIVE and TURN and low in IDLE.
REQ-026 gnt SHALL never have more than one bit set, and SHALL be non-zero only when read is all-zeros.

Reset
REQ-027 On reset, the block SHALL set state=IDLE, gnt=0, read all-ones, regff=0, done=0, busy=0, and the last-served pointer to 1 so that requester 0 wins the first tie.
REQ-028 Reset asserted in DRIVE or TURN SHALL abort the transaction at the next edge, drive read all-ones, and produce no done pulse.
REQ-029 Reset SHALL take priority over every state transition, and req SHALL be ignored in the reset cycle.

Verification
REQ-030 Single request: HOLD=2, req=01 and wdata0=16'hA5A5 for one cycle -> next cycle gnt=01, regff=A5A5 and read=0 for 2 cycles, then 1 cycle of done=1 with read all-ones, then IDLE.
REQ-031 Tie after reset: req=11, wdata0=1111, wdata1=2222 held -> grant sequence gnt=01 (regff 1111), then gnt=10 (regff 2222), then 01; grant starts every 4 cycles.
REQ-032 Request drop: req=10 for one cycle only -> full HOLD-cycle DRIVE on requester 1, then done; no further grant.
REQ-033 Reset mid-DRIVE: HOLD=4, reset asserted in the 2nd DRIVE cycle -> following cycle gnt=0, read all-ones, regff=0, done never asserted.
REQ-034 HOLD=1 with req=01 held -> alternating single DRIVE cycle, TURN, IDLE; grant starts every 3 cycles; done once per grant.
REQ-035 Assertion checks across all tests: gnt is one-hot0; done is always one cycle wide; read is never zero in TURN or IDLE.
